mem_bus_arbiter: RTL and testbench

//  Parametrised N-master to 1-slave bus arbiter for the cs/we/ack memory bus used between MasterShell and memory.

---
 rtl/mem_bus_pkg.sv | 30 +++
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter_arb_pick.sv | 35 +++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the cs/we/ack memory bus arbiter: FSM state
// encoding and the width helpers used to size grant and timeout fields.
package mem_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Field widths never drop below one bit.
  function automatic int max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the master-side request/response signals and the slave-side
// command/ack signals around the arbiter. The slave modport is the
// arbiter's own view (it answers the masters and drives the memory);
// the master modport is the view of the surrounding masters and memory.
interface mem_bus_arbiter_if
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) ();

  localparam int GW = max1(clog2(NUM_MASTERS));

  logic [NUM_MASTERS-1:0]        i_m_cs;
  logic [NUM_MASTERS-1:0]        i_m_we;
  logic [NUM_MASTERS*ADDR_W-1:0] i_m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] i_m_dat;
  logic [DATA_W-1:0]             o_m_dat;
  logic [NUM_MASTERS-1:0]        o_m_ack;
  logic                          o_m_err;
  logic                          o_s_cs;
  logic                          o_s_we;
  logic [ADDR_W-1:0]             o_s_addr;
  logic [DATA_W-1:0]             o_s_dat;
  logic                          i_s_ack;
  logic [DATA_W-1:0]             i_s_dat;
  logic [GW-1:0]                 o_grant;
  logic                          o_busy;

  modport slave (
    input  i_m_cs, i_m_we, i_m_addr, i_m_dat, i_s_ack, i_s_dat,
    output o_m_dat, o_m_ack, o_m_err, o_s_cs, o_s_we, o_s_addr, o_s_dat,
    output o_grant, o_busy
  );

  modport master (
    output i_m_cs, i_m_we, i_m_addr, i_m_dat, i_s_ack, i_s_dat,
    input  o_m_dat, o_m_ack, o_m_err, o_s_cs, o_s_we, o_s_addr, o_s_dat,
    input  o_grant, o_busy
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational winner selection: first requester at or after the start
// pointer (wrapping) in round-robin mode, lowest index otherwise.
module arb_pick
  import mem_bus_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  input  logic          rr_mode_i,
  output logic [GW-1:0] idx_o,
  output logic          vld_o
);

  // Scan candidates in priority order and keep the first one requesting.
  always_comb begin
    int            c;
    logic [GW-1:0] ci;
    idx_o = '0;
    vld_o = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 0; i < N; i++) begin
      c = rr_mode_i ? (int'(ptr_i) + i) : i;
      if (c >= N) c = c - N;
      ci = GW'(c);
      if (!vld_o && req_i[ci]) begin
        vld_o = 1'b1;
        idx_o = ci;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to 1-slave arbiter for the cs/we/ack memory bus. Holds the
// IDLE/BUSY/DONE FSM, the latched slave command, the round-robin pointer
// and the optional ack timeout counter. Every output is a register.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int RR_MODE     = 1,
  parameter int TIMEOUT     = 0
) (
  input logic              i_clk,
  input logic              i_reset,
  mem_bus_arbiter_if.slave bus
);

  localparam int GW = max1(clog2(NUM_MASTERS));
  localparam int TW = max1(clog2(TIMEOUT + 1));

  state_e                 state_q, state_d;
  logic [GW-1:0]          ptr_q, ptr_d;
  logic [GW-1:0]          grant_q, grant_d;
  logic [TW-1:0]          cnt_q, cnt_d;
  logic                   s_cs_q, s_cs_d;
  logic                   s_we_q, s_we_d;
  logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
  logic [DATA_W-1:0]      s_dat_q, s_dat_d;
  logic [DATA_W-1:0]      m_dat_q, m_dat_d;
  logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;
  logic                   m_err_q, m_err_d;
  logic                   busy_q, busy_d;

  logic [GW-1:0]          pick_idx;
  logic                   pick_vld;

  arb_pick #(
    .N  (NUM_MASTERS),
    .GW (GW)
  ) u_pick (
    .req_i     (bus.i_m_cs),
    .ptr_i     (ptr_q),
    .rr_mode_i (RR_MODE != 0),
    .idx_o     (pick_idx),
    .vld_o     (pick_vld)
  );

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    s_cs_d   = s_cs_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_dat_d  = s_dat_q;
    m_dat_d  = m_dat_q;
    m_ack_d  = '0;
    m_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          // Latch the winner's command so it stays stable for all of BUSY.
          state_d  = S_BUSY;
          grant_d  = pick_idx;
          cnt_d    = '0;
          s_cs_d   = 1'b1;
          s_we_d   = bus.i_m_we[pick_idx];
          s_addr_d = bus.i_m_addr[pick_idx*ADDR_W +: ADDR_W];
          s_dat_d  = bus.i_m_dat[pick_idx*DATA_W +: DATA_W];
          if (RR_MODE != 0) begin
            ptr_d = (pick_idx == GW'(NUM_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
      end

      S_BUSY: begin
        // A slave ack always beats a timeout landing in the same cycle.
        if (bus.i_s_ack) begin
          state_d = S_DONE;
          s_cs_d  = 1'b0;
          m_dat_d = bus.i_s_dat;
          for (int k = 0; k < NUM_MASTERS; k++) begin
            m_ack_d[k] = (grant_q == GW'(k));
          end
        end else if ((TIMEOUT > 0) && (cnt_q == TW'(TIMEOUT))) begin
          state_d = S_DONE;
          s_cs_d  = 1'b0;
          m_dat_d = '0;
          m_err_d = 1'b1;
          for (int k = 0; k < NUM_MASTERS; k++) begin
            m_ack_d[k] = (grant_q == GW'(k));
          end
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // One quiet cycle so the finished master can release its cs.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset overrides any same-cycle ack.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      s_cs_q   <= 1'b0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_dat_q  <= '0;
      m_dat_q  <= '0;
      m_ack_q  <= '0;
      m_err_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      s_cs_q   <= s_cs_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_dat_q  <= s_dat_d;
      m_dat_q  <= m_dat_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.o_s_cs   = s_cs_q;
  assign bus.o_s_we   = s_we_q;
  assign bus.o_s_addr = s_addr_q;
  assign bus.o_s_dat  = s_dat_q;
  assign bus.o_m_dat  = m_dat_q;
  assign bus.o_m_ack  = m_ack_q;
  assign bus.o_m_err  = m_err_q;
  assign bus.o_grant  = grant_q;
  assign bus.o_busy   = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a two-master instance with a 5-cycle ack
// timeout driven by directed steps, plus two three-master instances
// (round-robin and fixed priority) fed by an always-acking slave.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       rst2 = 1'b1;
  logic       rst3 = 1'b1;
  logic [2:0] cs3  = 3'b000;

  mem_bus_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(16)) b2  ();
  mem_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(16)) b3r ();
  mem_bus_arbiter_if #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(16)) b3f ();

  mem_bus_arbiter #(.NUM_MASTERS(2), .ADDR_W(16), .DATA_W(16), .RR_MODE(1), .TIMEOUT(5))
    u2 (.i_clk(clk), .i_reset(rst2), .bus(b2.slave));
  mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(16), .RR_MODE(1), .TIMEOUT(0))
    u3r (.i_clk(clk), .i_reset(rst3), .bus(b3r.slave));
  mem_bus_arbiter #(.NUM_MASTERS(3), .ADDR_W(16), .DATA_W(16), .RR_MODE(0), .TIMEOUT(0))
    u3f (.i_clk(clk), .i_reset(rst3), .bus(b3f.slave));

  // Three-master slaves ack immediately and return their address as data.
  assign b3r.i_m_cs   = cs3;
  assign b3r.i_m_we   = 3'b000;
  assign b3r.i_m_addr = {16'h0A02, 16'h0A01, 16'h0A00};
  assign b3r.i_m_dat  = '0;
  assign b3r.i_s_ack  = b3r.o_s_cs;
  assign b3r.i_s_dat  = b3r.o_s_addr;
  assign b3f.i_m_cs   = cs3;
  assign b3f.i_m_we   = 3'b000;
  assign b3f.i_m_addr = {16'h0A02, 16'h0A01, 16'h0A00};
  assign b3f.i_m_dat  = '0;
  assign b3f.i_s_ack  = b3f.o_s_cs;
  assign b3f.i_s_dat  = b3f.o_s_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: {ack, dat, err} for the two-master DUT, grant index for the others.
  logic [18:0] q2[$];
  int          q3r[$];
  int          q3f[$];

  logic prev_cs3r  = 1'b0;
  logic seen_ack3r = 1'b0;
  int   last_ack3r = 0;

  always @(negedge clk) begin
    if (b2.o_m_ack != 2'b00) begin
      if (q2.size() == 0) begin
        chk("unexpected_ack2", 64'({b2.o_m_ack, b2.o_m_dat, b2.o_m_err}), 64'd0);
      end else begin
        logic [18:0] e;
        e = q2.pop_front();
        chk("ack2", 64'({b2.o_m_ack, b2.o_m_dat, b2.o_m_err}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (b3r.o_s_cs && !prev_cs3r && seen_ack3r) begin
      chk("rr_gap", 64'(cyc - last_ack3r), 64'd2);
    end
    prev_cs3r <= b3r.o_s_cs;
    if (b3r.o_m_ack != 3'b000) begin
      last_ack3r <= cyc;
      seen_ack3r <= 1'b1;
      if (q3r.size() == 0) begin
        chk("unexpected_ack_rr", 64'(b3r.o_m_ack), 64'd0);
      end else begin
        int g;
        logic [2:0]  ea;
        logic [15:0] ed;
        g  = q3r.pop_front();
        ea = 3'b001 << g;
        ed = 16'h0A00 + 16'(g);
        chk("rr_ack", 64'({b3r.o_m_ack, b3r.o_grant, b3r.o_m_dat, b3r.o_m_err}),
            64'({ea, 2'(g), ed, 1'b0}));
      end
    end
  end

  always @(negedge clk) begin
    if (b3f.o_m_ack != 3'b000) begin
      if (q3f.size() == 0) begin
        chk("unexpected_ack_fp", 64'(b3f.o_m_ack), 64'd0);
      end else begin
        int g;
        logic [2:0]  ea;
        logic [15:0] ed;
        g  = q3f.pop_front();
        ea = 3'b001 << g;
        ed = 16'h0A00 + 16'(g);
        chk("fp_ack", 64'({b3f.o_m_ack, b3f.o_grant, b3f.o_m_dat, b3f.o_m_err}),
            64'({ea, 2'(g), ed, 1'b0}));
      end
    end
  end

  initial begin
    int n;

    // Reset held three cycles with both masters requesting.
    b2.i_m_cs   = 2'b11;
    b2.i_m_we   = 2'b00;
    b2.i_m_addr = {16'h0123, 16'h0010};
    b2.i_m_dat  = {16'h0000, 16'h0000};
    b2.i_s_ack  = 1'b0;
    b2.i_s_dat  = 16'h0000;
    rst2 = 1'b1;
    step(); step(); step();
    chk("reset_outputs", 64'({b2.o_s_cs, b2.o_s_we, b2.o_s_addr, b2.o_s_dat, b2.o_m_dat,
                              b2.o_m_ack, b2.o_m_err, b2.o_grant, b2.o_busy}), 64'd0);

    // First grant one cycle after reset falls goes to master 0.
    rst2 = 1'b0;
    step();
    chk("first_grant", 64'({b2.o_s_cs, b2.o_grant, b2.o_busy, b2.o_s_addr}),
        64'({1'b1, 1'b0, 1'b1, 16'h0010}));
    b2.i_s_ack = 1'b1;
    b2.i_s_dat = 16'h1111;
    q2.push_back({2'b01, 16'h1111, 1'b0});
    step();
    b2.i_s_ack = 1'b0;
    b2.i_m_cs  = 2'b10;

    // Single read by master 1, granted two cycles after the previous ack.
    step();
    chk("gap_not_yet", 64'(b2.o_s_cs), 64'd0);
    step();
    chk("read_grant", 64'({b2.o_s_cs, b2.o_grant, b2.o_s_we, b2.o_s_addr}),
        64'({1'b1, 1'b1, 1'b0, 16'h0123}));
    step(); step();
    b2.i_s_ack = 1'b1;
    b2.i_s_dat = 16'hBEEF;
    q2.push_back({2'b10, 16'hBEEF, 1'b0});
    step();
    chk("read_ack", 64'({b2.o_m_ack, b2.o_m_dat, b2.o_s_cs}), 64'({2'b10, 16'hBEEF, 1'b0}));
    b2.i_s_ack = 1'b0;
    b2.i_m_cs  = 2'b00;
    step();
    chk("ack_one_cycle", 64'(b2.o_m_ack), 64'd0);
    step();

    // Write by master 0; the master changes addr/dat while BUSY.
    b2.i_m_we   = 2'b01;
    b2.i_m_addr = {16'h0123, 16'h1FFF};
    b2.i_m_dat  = {16'h0000, 16'hA5A5};
    b2.i_m_cs   = 2'b01;
    step();
    chk("write_cmd0", 64'({b2.o_s_cs, b2.o_s_we, b2.o_s_addr, b2.o_s_dat}),
        64'({1'b1, 1'b1, 16'h1FFF, 16'hA5A5}));
    b2.i_m_addr = {16'h0123, 16'h0000};
    b2.i_m_dat  = {16'h0000, 16'h0000};
    b2.i_m_we   = 2'b00;
    step();
    chk("write_cmd1", 64'({b2.o_s_cs, b2.o_s_we, b2.o_s_addr, b2.o_s_dat}),
        64'({1'b1, 1'b1, 16'h1FFF, 16'hA5A5}));
    step();
    chk("write_cmd2", 64'({b2.o_s_cs, b2.o_s_we, b2.o_s_addr, b2.o_s_dat}),
        64'({1'b1, 1'b1, 16'h1FFF, 16'hA5A5}));
    b2.i_s_ack = 1'b1;
    b2.i_s_dat = 16'h0042;
    q2.push_back({2'b01, 16'h0042, 1'b0});
    step();
    b2.i_s_ack = 1'b0;
    b2.i_m_cs  = 2'b00;
    step();

    // Timeout: master 1, slave silent, read data forced to zero.
    b2.i_m_cs  = 2'b10;
    b2.i_s_dat = 16'hFFFF;
    step();
    chk("to_grant", 64'({b2.o_s_cs, b2.o_grant}), 64'({1'b1, 1'b1}));
    q2.push_back({2'b10, 16'h0000, 1'b1});
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      n++;
      if (b2.o_m_ack != 2'b00) break;
    end
    chk("to_latency", 64'(n), 64'd6);
    chk("to_err", 64'({b2.o_m_err, b2.o_m_dat, b2.o_s_cs}), 64'({1'b1, 16'h0000, 1'b0}));
    b2.i_m_cs = 2'b00;
    step();
    step();

    // Ack arriving in the cycle the counter reaches the limit wins.
    b2.i_m_cs = 2'b01;
    step();
    chk("race_grant", 64'({b2.o_s_cs, b2.o_grant}), 64'({1'b1, 1'b0}));
    step(); step(); step(); step(); step();
    b2.i_s_ack = 1'b1;
    b2.i_s_dat = 16'h7777;
    q2.push_back({2'b01, 16'h7777, 1'b0});
    step();
    chk("race_no_err", 64'({b2.o_m_ack, b2.o_m_err, b2.o_m_dat}), 64'({2'b01, 1'b0, 16'h7777}));
    b2.i_s_ack = 1'b0;
    b2.i_m_cs  = 2'b00;
    step();
    step();

    // Reset in the same cycle as the slave ack drops the transfer.
    b2.i_m_cs = 2'b10;
    step();
    chk("mid_busy", 64'({b2.o_busy, b2.o_grant}), 64'({1'b1, 1'b1}));
    rst2       = 1'b1;
    b2.i_s_ack = 1'b1;
    b2.i_s_dat = 16'h1234;
    step();
    chk("reset_drop", 64'({b2.o_m_ack, b2.o_busy, b2.o_s_cs, b2.o_m_err}), 64'd0);
    rst2       = 1'b0;
    b2.i_s_ack = 1'b0;
    b2.i_m_cs  = 2'b00;
    step();
    step();
    chk("idle_after_reset", 64'({b2.o_busy, b2.o_m_ack}), 64'd0);

    // Three masters, all requesting: round robin vs fixed priority.
    q3r.push_back(0); q3r.push_back(1); q3r.push_back(2); q3r.push_back(0);
    q3f.push_back(0); q3f.push_back(0); q3f.push_back(0); q3f.push_back(0);
    step();
    cs3  = 3'b111;
    rst3 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (q3r.size() == 0 && q3f.size() == 0) break;
    end
    cs3 = 3'b000;
    chk("n3_done_in_budget", 64'(n < 40), 64'd1);
    step(); step(); step(); step();

    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q3r_drained", 64'(q3r.size()), 64'd0);
    chk("q3f_drained", 64'(q3f.size()), 64'd0);
    chk("n3_idle", 64'({b3r.o_busy, b3f.o_busy}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
